// File: rtl/inst_encoder_pkg.sv
// Shared opcode values, instruction field positions and encoder types.
// The core's field extraction uses the same positions so both sides stay in step.
package inst_encoder_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned INST_W = 32;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_MPY  = 5'd2;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'd3;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'd4;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_SRL  = 5'd7;
    localparam logic [OPC_W-1:0] OPC_SRA  = 5'd8;
    localparam logic [OPC_W-1:0] OPC_CMP  = 5'd9;
    localparam logic [OPC_W-1:0] OPC_MOV  = 5'd10;
    localparam logic [OPC_W-1:0] OPC_BR   = 5'd11;
    localparam logic [OPC_W-1:0] OPC_CALL = 5'd12;
    localparam logic [OPC_W-1:0] OPC_RET  = 5'd13;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'd14;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 27;
    localparam int unsigned SIMM_BIT = 26;
    localparam int unsigned SEXT_BIT = 25;
    localparam int unsigned Z_HI     = 20;
    localparam int unsigned Z_LO     = 16;
    localparam int unsigned NEG_BIT  = 19;
    localparam int unsigned PRED_HI  = 18;
    localparam int unsigned PRED_LO  = 16;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned CC_HI    = 12;
    localparam int unsigned CC_LO    = 10;
    localparam int unsigned A_HI     = 9;
    localparam int unsigned A_LO     = 5;
    localparam int unsigned B_HI     = 4;
    localparam int unsigned B_LO     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [4:0]       z;
        logic [4:0]       a;
        logic [4:0]       b;
        logic [2:0]       pred;
        logic [15:0]      imm;
        logic             small_imm;
        logic             b_sext;
        logic             negate;
        logic [2:0]       cc;
    } inst_fields_t;

    // ADD..SRA occupy a contiguous opcode range
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        return opc <= OPC_SRA;
    endfunction

    function automatic logic is_legal_op(input logic [OPC_W-1:0] opc);
        return opc <= OPC_HALT;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input and instruction-word output handshakes of the encoder.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [4:0]        in_z;
    logic [4:0]        in_a;
    logic [4:0]        in_b;
    logic [2:0]        in_pred;
    logic [15:0]       in_imm;
    logic              in_small_imm;
    logic              in_b_sext;
    logic              in_negate;
    logic [2:0]        in_cc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_opcode, in_z, in_a, in_b, in_pred, in_imm,
               in_small_imm, in_b_sext, in_negate, in_cc, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );

    modport master (
        output in_valid, in_opcode, in_z, in_a, in_b, in_pred, in_imm,
               in_small_imm, in_b_sext, in_negate, in_cc, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );
endinterface

// File: rtl/inst_skid_buffer.sv
// Two-entry in-order buffer; head entry drives the read side straight from registers.
// o_full_nxt_c lets the producer register its ready one cycle ahead.
module inst_skid_buffer #(
    parameter int unsigned W = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_valid,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_ready,
    output logic         o_rd_valid,
    output logic [W-1:0] o_rd_data,
    output logic         o_full_nxt_c
);
    logic [W-1:0] r_data0;
    logic [W-1:0] r_data1;
    logic         r_valid0;
    logic         r_valid1;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_wr_valid && !r_valid1;
    assign w_pop  = r_valid0 && i_rd_ready;

    assign o_rd_valid   = r_valid0;
    assign o_rd_data    = r_data0;
    assign o_full_nxt_c = r_valid1 ? !w_pop : (r_valid0 && w_push && !w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0  <= '0;
            r_data1  <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else if (w_pop) begin
            // second entry (or the incoming word) slides into the head
            if (r_valid1 || w_push) begin
                r_data0 <= r_valid1 ? r_data1 : i_wr_data;
            end
            r_valid0 <= r_valid1 || w_push;
            r_valid1 <= 1'b0;
        end else if (w_push) begin
            if (r_valid0) begin
                r_data1  <= i_wr_data;
                r_valid1 <= 1'b1;
            end else begin
                r_data0  <= i_wr_data;
                r_valid0 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them with
// sequential imem addresses until HALT or address overflow.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    inst_encoder_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic           error
);
    localparam int unsigned       BUF_W     = INST_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    enc_state_e        r_state;
    enc_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              w_error_nxt;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_full_nxt;
    logic              w_buf_valid;
    logic [BUF_W-1:0]  w_buf_data;
    inst_fields_t      w_fields;
    logic [INST_W-1:0] w_inst;

    function automatic logic [INST_W-1:0] pack_inst(input inst_fields_t f);
        logic [INST_W-1:0] word;
        word = '0;
        word[OPC_HI:OPC_LO] = f.opcode;
        if (is_alu_op(f.opcode) || f.opcode == OPC_CMP) begin
            word[SIMM_BIT]  = f.small_imm;
            word[SEXT_BIT]  = f.small_imm & f.b_sext;
            word[Z_HI:Z_LO] = f.z;
            word[A_HI:A_LO] = f.a;
            word[B_HI:B_LO] = f.b;
        end
        case (f.opcode)
            OPC_CMP:  word[CC_HI:CC_LO] = f.cc;
            OPC_MOV: begin
                word[Z_HI:Z_LO]     = f.z;
                word[IMM_HI:IMM_LO] = f.imm;
            end
            OPC_BR: begin
                word[NEG_BIT]         = f.negate;
                word[PRED_HI:PRED_LO] = f.pred;
                word[IMM_HI:IMM_LO]   = f.imm;
            end
            OPC_CALL: word[IMM_HI:IMM_LO] = f.imm;
            default:  ;
        endcase
        return word;
    endfunction

    assign w_fields = '{
        opcode:    bus.in_opcode,
        z:         bus.in_z,
        a:         bus.in_a,
        b:         bus.in_b,
        pred:      bus.in_pred,
        imm:       bus.in_imm,
        small_imm: bus.in_small_imm,
        b_sext:    bus.in_b_sext,
        negate:    bus.in_negate,
        cc:        bus.in_cc
    };

    assign w_inst   = pack_inst(w_fields);
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_legal  = is_legal_op(bus.in_opcode);
    assign w_push   = w_accept && w_legal;

    inst_skid_buffer #(
        .W (BUF_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_wr_valid   (w_push),
        .i_wr_data    ({r_addr, w_inst}),
        .i_rd_ready   (bus.out_ready),
        .o_rd_valid   (w_buf_valid),
        .o_rd_data    (w_buf_data),
        .o_full_nxt_c (w_full_nxt)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_buf_valid;
    assign bus.out_inst  = w_buf_data[INST_W-1:0];
    assign bus.out_addr  = w_buf_data[BUF_W-1:INST_W];
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_in_ready <= (w_state_nxt == ST_ENCODE) && !w_full_nxt;
            r_busy     <= (w_state_nxt == ST_ENCODE) || (w_state_nxt == ST_DRAIN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_error    <= w_error_nxt;
        end
    end

    // Run control: illegal bundles are dropped without consuming an address
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_error_nxt = r_error;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_ENCODE;
                    w_addr_nxt  = BASE;
                    w_error_nxt = 1'b0;
                end
            end
            ST_ENCODE: begin
                if (w_accept && !w_legal) begin
                    w_error_nxt = 1'b1;
                end else if (w_accept) begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    if (r_addr == LAST_ADDR) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                    if (bus.in_opcode == OPC_HALT) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!w_buf_valid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a 10-bit address instance for encoding and
// flow control, a 2-bit address instance for overflow and mid-stream reset.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sel;
    logic        v, simm, sext, neg, ordy;
    logic [4:0]  opc, fz, fa, fb;
    logic [2:0]  pred, cc;
    logic [15:0] imm;
    logic        busy1, done1, error1, busy2, done2, error2;

    inst_encoder_if #(.ADDR_W(10)) bus();
    inst_encoder_if #(.ADDR_W(2))  bus2();

    assign bus.in_valid      = v && !sel;
    assign bus2.in_valid     = v && sel;
    assign bus.in_opcode     = opc;   assign bus2.in_opcode    = opc;
    assign bus.in_z          = fz;    assign bus2.in_z         = fz;
    assign bus.in_a          = fa;    assign bus2.in_a         = fa;
    assign bus.in_b          = fb;    assign bus2.in_b         = fb;
    assign bus.in_pred       = pred;  assign bus2.in_pred      = pred;
    assign bus.in_imm        = imm;   assign bus2.in_imm       = imm;
    assign bus.in_small_imm  = simm;  assign bus2.in_small_imm = simm;
    assign bus.in_b_sext     = sext;  assign bus2.in_b_sext    = sext;
    assign bus.in_negate     = neg;   assign bus2.in_negate    = neg;
    assign bus.in_cc         = cc;    assign bus2.in_cc        = cc;
    assign bus.out_ready     = ordy;  assign bus2.out_ready    = ordy;

    inst_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .start(start && !sel), .bus(bus),
        .busy(busy1), .done(done1), .error(error1)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start && sel), .bus(bus2),
        .busy(busy2), .done(done2), .error(error2)
    );

    logic        s_in_ready, s_out_valid, s_busy, s_done, s_error;
    logic [31:0] s_out_inst;
    logic [9:0]  s_out_addr;
    assign s_in_ready  = sel ? bus2.in_ready  : bus.in_ready;
    assign s_out_valid = sel ? bus2.out_valid : bus.out_valid;
    assign s_out_inst  = sel ? bus2.out_inst  : bus.out_inst;
    assign s_out_addr  = sel ? 10'(bus2.out_addr) : bus.out_addr;
    assign s_busy      = sel ? busy2  : busy1;
    assign s_done      = sel ? done2  : done1;
    assign s_error     = sel ? error2 : error1;

    logic [31:0] q_inst[$];
    logic [9:0]  q_addr[$];
    always @(negedge clk) begin
        if (!rst && s_out_valid && ordy) begin
            q_inst.push_back(s_out_inst);
            q_addr.push_back(s_out_addr);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ew(input logic [4:0] o, input logic [31:0] lo);
        return (32'(o) << 27) | lo;
    endfunction

    task automatic drive(input logic [4:0] o, input logic [4:0] z, input logic [4:0] a,
                         input logic [4:0] b, input logic [2:0] p, input logic [15:0] im,
                         input logic si, input logic se, input logic ng, input logic [2:0] c);
        opc = o; fz = z; fa = a; fb = b; pred = p; imm = im;
        simm = si; sext = se; neg = ng; cc = c; v = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (s_in_ready) got = 1'b1;
        end
        check({tag, "_accepted"}, 64'(got), 64'(1));
        if (got) begin
            @(posedge clk); #1;
        end
        v = 1'b0;
    endtask

    task automatic send(input string tag, input logic [4:0] o, input logic [4:0] z,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] p,
                        input logic [15:0] im, input logic si, input logic se,
                        input logic ng, input logic [2:0] c);
        drive(o, z, a, b, p, im, si, se, ng, c);
        wait_accept(tag);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] inst, input logic [9:0] addr);
        for (int i = 0; i < 40 && q_inst.size() == 0; i++) @(negedge clk);
        check({tag, "_seen"}, 64'(q_inst.size() != 0), 64'(1));
        if (q_inst.size() != 0) begin
            check({tag, "_inst"}, 64'(q_inst.pop_front()), 64'(inst));
            check({tag, "_addr"}, 64'(q_addr.pop_front()), 64'(addr));
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !s_done; i++) @(negedge clk);
        check({tag, "_done"}, 64'(s_done), 64'(1));
        check({tag, "_busy"}, 64'(s_busy), 64'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, 64'(s_out_valid), 64'(0));
        check({tag, "_out_inst"},  64'(s_out_inst),  64'(0));
        check({tag, "_out_addr"},  64'(s_out_addr),  64'(0));
        check({tag, "_in_ready"},  64'(s_in_ready),  64'(0));
        check({tag, "_busy"},      64'(s_busy),      64'(0));
        check({tag, "_done"},      64'(s_done),      64'(0));
        check({tag, "_error"},     64'(s_error),     64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst = 1'b1; start = 1'b0; sel = 1'b0; ordy = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Run 1: reg-form ADD with latency check, then HALT
        do_start();
        @(negedge clk);
        check("start_busy", 64'(s_busy), 64'(1));
        check("start_in_ready", 64'(s_in_ready), 64'(1));
        @(posedge clk); #1;
        send("add", OPC_ADD, 5'd3, 5'd4, 5'd5, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check("add_lat_valid", 64'(s_out_valid), 64'(1));
        check("add_lat_inst", 64'(s_out_inst), 64'(ew(OPC_ADD, 32'h0003_0085)));
        check("add_lat_addr", 64'(s_out_addr), 64'(0));
        @(posedge clk); #1;
        send("halt1", OPC_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        expect_word("w_add", ew(OPC_ADD, 32'h0003_0085), 10'd0);
        expect_word("w_halt1", ew(OPC_HALT, 32'h0), 10'd1);
        wait_done("run1");
        check("run1_in_ready", 64'(s_in_ready), 64'(0));

        // Run 2: CMP with sign-extended imm5, negated BR, MOV with junk fields
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        check("restart_done", 64'(s_done), 64'(0));
        @(posedge clk); #1;
        send("cmp", OPC_CMP, 5'd1, 5'd2, 5'h1F, 3'd0, 16'd0, 1'b1, 1'b1, 1'b0, 3'd5);
        send("br", OPC_BR, 5'd0, 5'd0, 5'd0, 3'd2, 16'hFFF0, 1'b0, 1'b0, 1'b1, 3'd0);
        send("mov", OPC_MOV, 5'd7, 5'h1F, 5'd0, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd7);
        send("halt2", OPC_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        expect_word("w_cmp", ew(OPC_CMP, 32'h0601_145F), 10'd0);
        expect_word("w_br", ew(OPC_BR, 32'h000A_FFF0), 10'd1);
        expect_word("w_mov", ew(OPC_MOV, 32'h0007_1234), 10'd2);
        expect_word("w_halt2", ew(OPC_HALT, 32'h0), 10'd3);
        wait_done("run2");

        // Run 3: back-pressure, buffer fills after two words
        @(posedge clk); #1;
        do_start();
        ordy = 1'b0;
        send("sub", OPC_SUB, 5'd1, 5'd2, 5'd3, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        send("xor", OPC_XOR, 5'd31, 5'd0, 5'h10, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(OPC_SRA, 5'd2, 5'd3, 5'd4, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(s_in_ready), 64'(0));
            check("bp_valid", 64'(s_out_valid), 64'(1));
            check("bp_inst", 64'(s_out_inst), 64'(ew(OPC_SUB, 32'h0001_0043)));
            check("bp_addr", 64'(s_out_addr), 64'(0));
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        wait_accept("sra");
        send("halt3", OPC_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        expect_word("w_sub", ew(OPC_SUB, 32'h0001_0043), 10'd0);
        expect_word("w_xor", ew(OPC_XOR, 32'h041F_0010), 10'd1);
        expect_word("w_sra", ew(OPC_SRA, 32'h0002_0064), 10'd2);
        expect_word("w_halt3", ew(OPC_HALT, 32'h0), 10'd3);
        wait_done("run3");

        // Run 4: illegal opcode is dropped, sets error, consumes no address
        @(posedge clk); #1;
        do_start();
        send("mov4", OPC_MOV, 5'd2, 5'd0, 5'd0, 3'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 3'd0);
        send("illegal", 5'd31, 5'd1, 5'd1, 5'd1, 3'd1, 16'h1111, 1'b1, 1'b1, 1'b1, 3'd1);
        @(negedge clk);
        check("illegal_error", 64'(s_error), 64'(1));
        check("illegal_in_ready", 64'(s_in_ready), 64'(1));
        @(posedge clk); #1;
        send("halt4", OPC_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        expect_word("w_mov4", ew(OPC_MOV, 32'h0002_BEEF), 10'd0);
        expect_word("w_halt4", ew(OPC_HALT, 32'h0), 10'd1);
        wait_done("run4");
        check("run4_error", 64'(s_error), 64'(1));
        @(posedge clk); #1;
        do_start();
        @(negedge clk);
        check("start_clears_error", 64'(s_error), 64'(0));
        @(posedge clk); #1;
        send("halt4b", OPC_HALT, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        expect_word("w_halt4b", ew(OPC_HALT, 32'h0), 10'd0);
        wait_done("run4b");

        // Run 5: 2-bit address space overflows after four words
        @(posedge clk); #1;
        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++)
            send("ovf", OPC_ADD, 5'd1, 5'd2, 5'd3, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(OPC_ADD, 5'd1, 5'd2, 5'd3, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_in_ready) acc = 1'b1;
        end
        check("ovf_5th_accepted", 64'(acc), 64'(0));
        @(posedge clk); #1;
        v = 1'b0;
        for (int i = 0; i < 4; i++)
            expect_word("w_ovf", ew(OPC_ADD, 32'h0001_0043), 10'(i));
        wait_done("ovf");
        check("ovf_error", 64'(s_error), 64'(1));
        check("ovf_no_extra", 64'(q_inst.size()), 64'(0));

        // Run 6: reset mid-stream discards buffered words and sticky error
        @(posedge clk); #1;
        do_start();
        send("illegal6", 5'd20, 5'd0, 5'd0, 5'd0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        ordy = 1'b0;
        send("ms1", OPC_OR, 5'd4, 5'd5, 5'd6, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        send("ms2", OPC_AND, 5'd4, 5'd5, 5'd6, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check("ms_error_before", 64'(s_error), 64'(1));
        check("ms_valid_before", 64'(s_out_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        ordy = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_words", 64'(q_inst.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Packs decoded instruction fields (opcode, register selectors, immediates, flags) into 32-bit instruction words.
- Streams the words, each with a sequential write address, into instruction memory.
- Performs the inverse of the core's field extraction; used by the program loader and by test harnesses to build imem images.
- Valid/ready on both sides, 2-entry output buffer, run-control FSM that stops after HALT.

Parameters:
- ADDR_W, 10, width of out_addr; image holds up to 2**ADDR_W words
- BASE_ADDR, 0, first address written after start

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  one-cycle pulse; arms encoder, loads address counter with BASE_ADDR, clears error
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts bundle this cycle
- in_opcode  in  5  opcode per `defines.vh
- in_z  in  5  destination reg (scalar, or predicate for CMP)
- in_a  in  5  source A reg
- in_b  in  5  source B reg, or imm5 when in_small_imm
- in_pred  in  3  BR predicate register
- in_imm  in  16  large immediate (MOV/BR/CALL)
- in_small_imm  in  1  ALU B operand is immediate
- in_b_sext  in  1  small immediate is sign-extended
- in_negate  in  1  BR negated
- in_cc  in  3  CMP condition code
- out_valid  out  1  word valid
- out_ready  in  1  memory accepts word
- out_inst  out  32  encoded word
- out_addr  out  ADDR_W  imem address of out_inst
- busy  out  1  FSM not IDLE/DONE
- done  out  1  HALT emitted and buffer drained
- error  out  1  sticky: illegal opcode or address overflow

Behaviour:
- Reset: FSM=IDLE; out_valid=0, out_inst=0, out_addr=0, in_ready=0, busy=0, done=0, error=0; buffer emptied. Reset mid-stream discards buffered words.
- FSM states:
  - IDLE: start -> ENCODE.
  - ENCODE: accepted HALT -> DRAIN; overflow -> DRAIN.
  - DRAIN: buffer empty -> DONE.
  - DONE: start -> ENCODE.
  - start in ENCODE/DRAIN is ignored.
- in_ready = (state==ENCODE) && buffer has a free entry. Registered; never depends combinationally on out_ready.
- Transfer: accept when in_valid && in_ready. Word appears at out_valid the next cycle if buffer empty (latency 1).
- out_valid/out_inst/out_addr are stable while out_valid && !out_ready. Order preserved.
- Address counter:
  - increments per accepted legal bundle; illegal bundles consume no address.
  - accepting a legal bundle at address 2**ADDR_W-1 emits it, then sets error and goes to DRAIN (no wrap).
- Encoding: opcode always in [31:27]; every bit not listed for the format is 0.
  - ALU (ADD SUB MPY AND OR XOR SHL SRL SRA): [26]=small_imm, [25]=small_imm&b_sext, [20:16]=z, [9:5]=a, [4:0]=b.
  - CMP: ALU format plus [12:10]=cc.
  - MOV: [20:16]=z, [15:0]=imm.
  - BR: [19]=negate, [18:16]=pred, [15:0]=imm.
  - CALL: [15:0]=imm. The R31 link is implicit.
  - RET, HALT: opcode only.
- in_b_sext without in_small_imm is ignored (bit 25 = 0).
- Illegal opcode (not in the list above): bundle accepted and dropped, error set; stays in ENCODE.
- Simultaneous accept and emit when buffer full: both occur and occupancy is unchanged.
- done stays high in DONE until start; busy=1 in ENCODE and DRAIN.

Decomposition:
- Opcode macros stay in `defines.vh`.
- Add field-position constants there (OPC_HI/LO, Z, A, B, CC, PRED, NEG, SIMM, SEXT, IMM ranges) so the core's field extraction and this encoder share them.
- Combinational packing is a function inside inst_encoder.
- One sub-module: inst_skid_buffer (2-entry, width 32+ADDR_W, valid/ready both sides).

Test Plan:
- start; ADD z=3 a=4 b=5, reg form, out_ready=1 -> next cycle out_inst=(`ADD<<27)|0x00030085, out_addr=0.
- CMP z=1 a=2 b=0x1F small_imm=1 sext=1 cc=5 -> (`CMP<<27)|0x0601145F. Then BR negate=1 pred=2 imm=0xFFF0 -> (`BR<<27)|0x000AFFF0 at addr 1.
- MOV z=7 imm=0x1234 with in_a=0x1F and in_cc=7 driven as junk -> (`MOV<<27)|0x00071234; junk fields absent.
- Hold out_ready=0 for 5 cycles while feeding 3 bundles -> in_ready drops after 2 accepted; outputs stable; all 3 words emitted in order with addrs 0,1,2.
- Feed MOV, illegal opcode, HALT -> error=1; MOV at addr 0, HALT at addr 1 (illegal consumed no address); done=1 after drain; start clears error.
- ADDR_W=2: 5 legal bundles -> addrs 0..3 emitted, 5th never accepted, error=1, done=1. Then assert rst mid-stream in a new run -> all outputs return to reset values next cycle.
